multicycle_controller: RTL and testbench

Sequencing FSM for the multicycle RV32I core variant. It steps the shared datapath (single ALU, unified instruction/data memory, register bank) through fetch, decode, execute, memory and writeback. It drives every datapath select and write enable, and handshakes with the memory port. It traps on illegal opcodes and on memory timeouts.

---
 rtl/multicycle_controller_if.sv | 35 +++
 rtl/multicycle_controller.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller and its datapath.
interface multicycle_controller_if;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       mem_addr_sel;
   logic       ir_write;
   logic       pc_write;
   logic       pc_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       reg_write;
   logic [1:0] result_src;
   logic       instr_done;
   logic       trap;
   logic [1:0] trap_cause;
   logic [3:0] state;

   modport master (
      input  opcode, branch_taken, mem_ready,
      output mem_req, mem_write, mem_addr_sel, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, result_src,
             instr_done, trap, trap_cause, state
   );

   modport slave (
      output opcode, branch_taken, mem_ready,
      input  mem_req, mem_write, mem_addr_sel, ir_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_write, result_src,
             instr_done, trap, trap_cause, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath: fetch, decode, execute,
// memory and writeback, with traps on illegal opcodes and memory timeouts.
module multicycle_controller #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   multicycle_controller_if.master bus
);
   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JAL       = 4'd10,
      S_JALR      = 4'd11,
      S_EXEC_U    = 4'd12,
      S_TRAP      = 4'd15
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       mem_req_c, mem_write_c, mem_addr_sel_c, ir_write_c;
   logic       pc_write_c, pc_src_c, reg_write_c, instr_done_c, trap_c;
   logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
   logic       timeout_c, is_mem_c;

   assign timeout_c = (cnt_q == CNT_W'(MEM_TIMEOUT));
   assign is_mem_c  = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                      (state_q == S_MEM_WRITE);

   // State, trap cause and wait-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cause_q <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and Moore output decode, qualified by mem_ready/branch_taken.
   always_comb begin
      state_d        = state_q;
      cause_d        = cause_q;
      mem_req_c      = 1'b0;
      mem_write_c    = 1'b0;
      mem_addr_sel_c = 1'b0;
      ir_write_c     = 1'b0;
      pc_write_c     = 1'b0;
      pc_src_c       = 1'b0;
      alu_src_a_c    = 2'b00;
      alu_src_b_c    = 2'b00;
      alu_op_c       = 2'b00;
      reg_write_c    = 1'b0;
      result_src_c   = 2'b00;
      instr_done_c   = 1'b0;
      trap_c         = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c   = 1'b1;
            alu_src_b_c = 2'b10;
            if (bus.mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (timeout_c) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_DECODE: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            case (bus.opcode)
               7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
               7'b0110011:             state_d = S_EXEC_R;
               7'b0010011:             state_d = S_EXEC_I;
               7'b1100011:             state_d = S_BRANCH;
               7'b1101111:             state_d = S_JAL;
               7'b1100111:             state_d = S_JALR;
               7'b0110111, 7'b0010111: state_d = S_EXEC_U;
               default: begin
                  state_d = S_TRAP;
                  cause_d = 2'b01;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            state_d     = bus.opcode[5] ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_req_c      = 1'b1;
            mem_addr_sel_c = 1'b1;
            if (bus.mem_ready) begin
               state_d = S_MEM_WB;
            end else if (timeout_c) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_MEM_WB: begin
            reg_write_c  = 1'b1;
            result_src_c = 2'b01;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_req_c      = 1'b1;
            mem_write_c    = 1'b1;
            mem_addr_sel_c = 1'b1;
            if (bus.mem_ready) begin
               instr_done_c = 1'b1;
               state_d      = S_FETCH;
            end else if (timeout_c) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end
         end
         S_EXEC_R: begin
            alu_src_a_c = 2'b10;
            alu_op_c    = 2'b10;
            state_d     = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            alu_op_c    = 2'b10;
            state_d     = S_ALU_WB;
         end
         S_EXEC_U: begin
            alu_src_a_c = bus.opcode[5] ? 2'b11 : 2'b01;
            alu_src_b_c = 2'b01;
            state_d     = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_c  = 1'b1;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_c  = 2'b10;
            alu_op_c     = 2'b01;
            pc_src_c     = 1'b1;
            pc_write_c   = bus.branch_taken;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
         end
         S_JAL, S_JALR: begin
            alu_src_a_c  = (state_q == S_JALR) ? 2'b10 : 2'b01;
            alu_src_b_c  = 2'b01;
            pc_write_c   = 1'b1;
            reg_write_c  = 1'b1;
            result_src_c = 2'b10;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
         end
         S_TRAP: begin
            trap_c = 1'b1;
         end
         default: begin
            state_d = S_TRAP;
            cause_d = 2'b01;
         end
      endcase
   end

   // Wait counter: counts stalled request cycles, cleared on any state change or ready.
   always_comb begin
      cnt_d = '0;
      if (is_mem_c && !bus.mem_ready && (state_d == state_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Output drive; everything is held low while reset is asserted.
   assign bus.mem_req      = rst_n & mem_req_c;
   assign bus.mem_write    = rst_n & mem_write_c;
   assign bus.mem_addr_sel = rst_n & mem_addr_sel_c;
   assign bus.ir_write     = rst_n & ir_write_c;
   assign bus.pc_write     = rst_n & pc_write_c;
   assign bus.pc_src       = rst_n & pc_src_c;
   assign bus.reg_write    = rst_n & reg_write_c;
   assign bus.instr_done   = rst_n & instr_done_c;
   assign bus.trap         = rst_n & trap_c;
   assign bus.alu_src_a    = rst_n ? alu_src_a_c  : 2'b00;
   assign bus.alu_src_b    = rst_n ? alu_src_b_c  : 2'b00;
   assign bus.alu_op       = rst_n ? alu_op_c     : 2'b00;
   assign bus.result_src   = rst_n ? result_src_c : 2'b00;
   assign bus.trap_cause   = rst_n ? cause_q      : 2'b00;
   assign bus.state        = rst_n ? 4'(state_q)  : 4'd0;
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle comparison of all
// outputs against an instruction-level schedule model.
module tb_multicycle_controller;
   localparam int unsigned MEM_TIMEOUT = 4;

   typedef struct packed {
      logic [3:0] st;
      logic       mem_req;
      logic       mem_write;
      logic       addr_sel;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] op;
      logic       reg_write;
      logic [1:0] rs;
      logic       done;
      logic       trap;
      logic [1:0] cause;
   } out_t;

   typedef struct {
      out_t       o;
      logic       mr;
      logic       bt;
      logic [6:0] opc;
   } cyc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   cyc_t plan_q[$];

   multicycle_controller_if bus();

   multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic out_t observe();
      out_t o;
      o.st        = bus.state;
      o.mem_req   = bus.mem_req;
      o.mem_write = bus.mem_write;
      o.addr_sel  = bus.mem_addr_sel;
      o.ir_write  = bus.ir_write;
      o.pc_write  = bus.pc_write;
      o.pc_src    = bus.pc_src;
      o.a         = bus.alu_src_a;
      o.b         = bus.alu_src_b;
      o.op        = bus.alu_op;
      o.reg_write = bus.reg_write;
      o.rs        = bus.result_src;
      o.done      = bus.instr_done;
      o.trap      = bus.trap;
      o.cause     = bus.trap_cause;
      return o;
   endfunction

   function automatic void push(input out_t o, input logic mr, input logic bt, input logic [6:0] opc);
      cyc_t c;
      c.o = o; c.mr = mr; c.bt = bt; c.opc = opc;
      plan_q.push_back(c);
   endfunction

   function automatic out_t trap_out(input logic [1:0] cause);
      out_t o = '0;
      o.st = 4'd15; o.trap = 1'b1; o.cause = cause;
      return o;
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction, with fw/mw wait cycles.
   function automatic void plan_instr(input logic [6:0] opc, input int fw, input int mw, input logic bt);
      out_t o;
      for (int i = 0; i <= fw; i++) begin
         o = '0; o.st = 4'd0; o.mem_req = 1'b1; o.b = 2'b10;
         if (i == fw) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
         push(o, (i == fw), rbit(), opc);
      end
      o = '0; o.st = 4'd1; o.a = 2'b01; o.b = 2'b01;
      push(o, rbit(), rbit(), opc);
      case (opc)
         7'b0000011, 7'b0100011: begin
            o = '0; o.st = 4'd2; o.a = 2'b10; o.b = 2'b01;
            push(o, rbit(), rbit(), opc);
            for (int i = 0; i <= mw; i++) begin
               o = '0; o.mem_req = 1'b1; o.addr_sel = 1'b1;
               if (opc == 7'b0000011) o.st = 4'd3;
               else begin
                  o.st = 4'd5; o.mem_write = 1'b1; o.done = (i == mw);
               end
               push(o, (i == mw), rbit(), opc);
            end
            if (opc == 7'b0000011) begin
               o = '0; o.st = 4'd4; o.reg_write = 1'b1; o.rs = 2'b01; o.done = 1'b1;
               push(o, rbit(), rbit(), opc);
            end
         end
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
            o = '0;
            if (opc == 7'b0110011) begin o.st = 4'd6; o.a = 2'b10; o.op = 2'b10; end
            else if (opc == 7'b0010011) begin o.st = 4'd7; o.a = 2'b10; o.b = 2'b01; o.op = 2'b10; end
            else if (opc == 7'b0110111) begin o.st = 4'd12; o.a = 2'b11; o.b = 2'b01; end
            else begin o.st = 4'd12; o.a = 2'b01; o.b = 2'b01; end
            push(o, rbit(), rbit(), opc);
            o = '0; o.st = 4'd8; o.reg_write = 1'b1; o.done = 1'b1;
            push(o, rbit(), rbit(), opc);
         end
         7'b1100011: begin
            o = '0; o.st = 4'd9; o.a = 2'b10; o.op = 2'b01; o.pc_src = 1'b1;
            o.pc_write = bt; o.done = 1'b1;
            push(o, rbit(), bt, opc);
         end
         7'b1101111, 7'b1100111: begin
            o = '0; o.b = 2'b01; o.pc_write = 1'b1; o.reg_write = 1'b1; o.rs = 2'b10; o.done = 1'b1;
            if (opc == 7'b1101111) begin o.st = 4'd10; o.a = 2'b01; end
            else begin o.st = 4'd11; o.a = 2'b10; end
            push(o, rbit(), rbit(), opc);
         end
         default: push(trap_out(2'b01), rbit(), rbit(), opc);
      endcase
   endfunction

   // Play up to max_cycles planned cycles; entered and left on a falling edge.
   task automatic run_q(input string name, input int max_cycles);
      cyc_t c;
      out_t got;
      int   n = 0;
      while (plan_q.size() > 0 && n < max_cycles) begin
         c = plan_q.pop_front();
         bus.mem_ready = c.mr; bus.branch_taken = c.bt; bus.opcode = c.opc;
         #1;
         got = observe();
         checks++;
         if (got !== c.o) begin
            errors++;
            $display("FAIL %s cycle %0d: state got=%0d exp=%0d, outputs got=%h exp=%h",
                     name, n, got.st, c.o.st, got, c.o);
         end
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input string name);
      out_t got;
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         got = observe();
         checks++;
         if (got !== out_t'(0)) begin
            errors++;
            $display("FAIL %s in reset: outputs got=%h exp=0", name, got);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.state !== 4'd0 || bus.trap !== 1'b0 || bus.trap_cause !== 2'b00) begin
         errors++;
         $display("FAIL %s after release: state=%0d trap=%b cause=%b exp 0/0/0",
                  name, bus.state, bus.trap, bus.trap_cause);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      out_t got;
      rst_n = 1'b0; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1; bus.opcode = 7'b0110011;
      #1;
      got = observe();
      checks++;
      if (got !== out_t'(0)) begin
         errors++;
         $display("FAIL reset_outputs: got=%h exp=0", got);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      plan_instr(7'b0110011, 0, 0, 1'b0);
      run_q("add", 100);
   endtask

   task automatic test_load_waits();
      plan_instr(7'b0000011, 0, 2, 1'b0);
      run_q("load_2wait", 100);
   endtask

   task automatic test_branch();
      plan_instr(7'b1100011, 0, 0, 1'b1);
      run_q("branch_taken", 100);
      plan_instr(7'b1100011, 0, 0, 1'b0);
      run_q("branch_not_taken", 100);
   endtask

   task automatic test_random();
      logic [6:0] ops [10];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0110011};
      for (int k = 0; k < 40; k++) begin
         plan_instr(ops[$urandom_range(0, 9)], int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), rbit());
      end
      run_q("random", 5000);
   endtask

   task automatic test_illegal();
      plan_instr(7'b1111111, 0, 0, 1'b0);
      for (int i = 0; i < 20; i++) push(trap_out(2'b01), rbit(), rbit(), 7'b1111111);
      run_q("illegal", 100);
      do_reset("illegal_reset");
   endtask

   task automatic test_timeout();
      out_t o;
      for (int i = 0; i <= int'(MEM_TIMEOUT); i++) begin
         o = '0; o.st = 4'd0; o.mem_req = 1'b1; o.b = 2'b10;
         push(o, 1'b0, rbit(), 7'b0110011);
      end
      for (int i = 0; i < 4; i++) push(trap_out(2'b10), rbit(), rbit(), 7'b0110011);
      run_q("fetch_timeout", 100);
      do_reset("timeout_reset");
   endtask

   task automatic test_reset_mid_write();
      plan_instr(7'b0100011, 0, 3, 1'b0);
      run_q("store_pre_reset", 4);
      plan_q.delete();
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_write !== 1'b1 || bus.mem_req !== 1'b1 || bus.state !== 4'd5) begin
         errors++;
         $display("FAIL store_wait: mem_write=%b mem_req=%b state=%0d exp 1/1/5",
                  bus.mem_write, bus.mem_req, bus.state);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.mem_write !== 1'b0 || bus.mem_req !== 1'b0 || bus.state !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_drop: mem_write=%b mem_req=%b state=%0d exp 0/0/0",
                  bus.mem_write, bus.mem_req, bus.state);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      plan_instr(7'b0010011, 1, 0, 1'b0);
      run_q("after_reset_addi", 100);
   endtask

   task automatic test_back_to_back();
      plan_instr(7'b0100011, 0, 0, 1'b0);
      plan_instr(7'b1101111, 0, 0, 1'b0);
      plan_instr(7'b0110111, 2, 0, 1'b0);
      plan_instr(7'b0000011, 3, 3, 1'b0);
      run_q("back_to_back", 200);
   endtask

   initial begin
      bus.mem_ready = 1'b0;
      bus.branch_taken = 1'b0;
      bus.opcode = 7'b0;
      test_reset();
      test_add();
      test_load_waits();
      test_branch();
      test_back_to_back();
      test_random();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
